// File: rtl/flag_bank.sv
// ============================================================================
// Module   : flag_bank
// Purpose  : Condition-flag register bank with per-bit write enables, forwarding
//            and a LIFO of flag checkpoints for branch-mispredict recovery.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module flag_bank #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             new_flags,
  input  logic [WIDTH-1:0]             flag_en,
  input  logic                         stall,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         restore,
  output logic [WIDTH-1:0]             q,
  output logic [WIDTH-1:0]             q_fwd,
  output logic [$clog2(DEPTH+1)-1:0]   depth_cnt,
  output logic                         full,
  output logic                         empty,
  output logic                         err
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] flags_q, flags_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [WIDTH-1:0] top_w;
  logic [WIDTH-1:0] wmask_w;
  logic             wr_en_w;
  logic             full_w, empty_w;
  logic             ent_we_w;
  logic [CNT_W-1:0] ent_idx_w;

  assign wr_en_w = ~stall & ~restore;
  assign wmask_w = flag_en & {WIDTH{wr_en_w}};
  assign q_fwd   = (wmask_w & new_flags) | (~wmask_w & flags_q);

  assign full_w  = (cnt_q == CNT_W'(DEPTH));
  assign empty_w = (cnt_q == '0);

  // Top of stack is entry cnt_q-1; compare-select keeps the index width-neutral.
  always_comb begin
    top_w = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (cnt_q == CNT_W'(i + 1)) top_w = stack_q[i];
    end
  end

  always_comb begin
    flags_d   = flags_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    ent_we_w  = 1'b0;
    ent_idx_w = '0;
    if (restore) begin
      if (!empty_w) begin
        flags_d = top_w;
        cnt_d   = cnt_q - CNT_W'(1);
      end else begin
        err_d = 1'b1;
      end
    end else if (!stall) begin
      flags_d = q_fwd;
      if (push && pop) begin
        ent_we_w = 1'b1;
        if (empty_w) begin
          ent_idx_w = '0;
          cnt_d     = CNT_W'(1);
        end else begin
          ent_idx_w = cnt_q - CNT_W'(1);
        end
      end else if (push) begin
        if (full_w) begin
          err_d = 1'b1;
        end else begin
          ent_we_w  = 1'b1;
          ent_idx_w = cnt_q;
          cnt_d     = cnt_q + CNT_W'(1);
        end
      end else if (pop) begin
        if (empty_w) err_d = 1'b1;
        else         cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        stack_q[gi] <= '0;
      end else if (ent_we_w && (ent_idx_w == CNT_W'(gi))) begin
        stack_q[gi] <= q_fwd;
      end
    end
  end

  assign q         = flags_q;
  assign depth_cnt = cnt_q;
  assign full      = full_w;
  assign empty     = empty_w;
  assign err       = err_q;

endmodule

`default_nettype wire
